spi_line_conditioner: RTL and testbench
=======================================

Name: spi_line_conditioner

Overview:
Upstream front-end for the SPI slave. Takes the raw ss/mosi/sck lines driven by the HPS PIO bit-bang outputs (asynchronous to clk, slow, possibly glitchy) and produces synchronised, deglitched lines plus single-cycle event strobes: sck edges, frame start/end, sampled MOSI bit, byte completion. It also flags framing errors and stalled frames. It feeds the spi_slave and data_transfer_controller in the 50 MHz clk domain.

Parameters:
FILTER_LEN, 4, consecutive stable synchronised samples required before a clean line changes (1..15)
TIMEOUT_CYCLES, 50000000, clk cycles with ss asserted and no sck edge before timeout fires (1 s at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-low reset
ss_in  input  1  raw chip select, active-low
mosi_in  input  1  raw MOSI
sck_in  input  1  raw SPI clock, mode 0 (CPOL=0, CPHA=0)
err_clr  input  1  synchronous pulse; clears sticky framing_error
ss_clean  output  1  filtered ss
mosi_clean  output  1  filtered mosi
sck_clean  output  1  filtered sck
sck_rise  output  1  1-cycle pulse on clean sck 0->1 while frame_active
sck_fall  output  1  1-cycle pulse on clean sck 1->0 while frame_active
mosi_bit  output  1  mosi_clean captured at sck_rise
bit_idx  output  3  bits received in current byte (0..7)
byte_strobe  output  1  1-cycle pulse on the 8th sck_rise of a byte
frame_start  output  1  1-cycle pulse on clean ss 1->0
frame_end  output  1  1-cycle pulse on clean ss 0->1
frame_active  output  1  high while frame open
framing_error  output  1  sticky; frame ended with bit_idx != 0
timeout  output  1  1-cycle pulse when stall limit reached

Behaviour:
- Reset (rst=0, async): sync stages for ss=1, mosi=0, sck=0; ss_clean=1, mosi_clean=0, sck_clean=0; all strobes 0; bit_idx=0; mosi_bit=0; frame_active=0; framing_error=0; filter and timeout counters 0; FSM=IDLE.
- Per line: 2-FF synchroniser, then filter. Counter resets to 0 whenever the synchronised value equals the clean value; otherwise it increments; when it reaches FILTER_LEN-1 the clean value toggles and the counter clears. Latency from raw edge to clean edge is 2+FILTER_LEN cycles. Glitches shorter than FILTER_LEN cycles are suppressed. Counter width is $clog2(FILTER_LEN+1).
- Edge strobes come from the clean value registered against its previous value. Strobes are asserted in the cycle after the clean transition.
- FSM, states IDLE, ACTIVE, STALLED:
  IDLE -> ACTIVE on clean ss fall: frame_start=1, bit_idx=0, timeout counter=0.
  ACTIVE: on sck_rise, mosi_bit<=mosi_clean and bit_idx increments mod 8. When bit_idx was 7, byte_strobe=1 and bit_idx wraps to 0. Any sck edge clears the timeout counter; otherwise it increments.
  ACTIVE -> STALLED when the counter reaches TIMEOUT_CYCLES-1: timeout=1 once. STALLED ignores sck edges.
  ACTIVE or STALLED -> IDLE on clean ss rise: frame_end=1, frame_active=0. If bit_idx!=0, framing_error<=1. bit_idx is then cleared to 0.
- frame_active=1 in ACTIVE and STALLED.
- Simultaneous events:
  - ss rise and sck edge in the same cycle: the ss rise wins, the edge is ignored, and no byte_strobe fires.
  - err_clr and a new framing error in the same cycle: set wins.
  - ss fall while STALLED cannot occur; ss must rise first.
- sck edges while IDLE: sck_clean still tracks the line, but sck_rise and sck_fall stay 0 and bit_idx stays put.
- Reset mid-frame: everything returns to reset values immediately, and no frame_end is generated.
- Timeout counter width is $clog2(TIMEOUT_CYCLES) and it saturates; it does not wrap.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, STALLED=2'd2)
  - SPI_BITS_PER_BYTE=8
  - default FILTER_LEN and TIMEOUT_CYCLES constants, reused by spi_slave and data_transfer_controller
- One sub-module: line_filter (synchroniser + stability counter + registered clean output + rise/fall pulses, params FILTER_LEN and RESET_VAL), instantiated three times. The FSM, bit counter and timeout live in the top of this block.

Test Plan:
- Reset release, lines idle (ss=1, sck=0) -> all outputs at reset values, no strobes for 1000 cycles.
- ss low, then 8 sck pulses (40-cycle half-period) with MOSI=0xA5 MSB first -> frame_start once; 8 sck_rise; mosi_bit sequence 1,0,1,0,0,1,0,1; byte_strobe once on the 8th rise; bit_idx back to 0; first clean ss edge 6 cycles after the raw edge (FILTER_LEN=4).
- 2-cycle glitches on sck and ss during IDLE and mid-bit -> no clean-line change, no strobes, bit_idx unchanged.
- ss rises after 5 bits -> frame_end, framing_error=1 and held until an err_clr pulse, then 0; a clean 16-bit frame afterwards leaves it 0.
- TIMEOUT_CYCLES=100, ss low and no sck -> timeout pulse exactly once; later sck pulses give no sck_rise; ss rise -> frame_end, FSM IDLE.
- rst asserted mid-byte at bit_idx=3 -> immediate reset values with no frame_end; the next frame counts from bit 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI front-end definitions: FSM encoding, byte geometry and the
// default line-filter / stall-timeout settings used by the SPI blocks.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_STALLED = 2'd2
    } spi_state_e;

    localparam int SPI_BITS_PER_BYTE      = 8;
    localparam int SPI_BIT_IDX_W          = $clog2(SPI_BITS_PER_BYTE);
    localparam int DEFAULT_FILTER_LEN     = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

    // Counter width for a count limit, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/spi_line_conditioner_if.sv
// Bundle of raw SPI lines in and conditioned lines / event strobes out.
// Strobe semantics: every *_rise, *_fall, frame_*, byte_strobe and timeout
// output is a single-cycle pulse, valid for exactly one clk cycle, with no
// back-pressure; consumers must sample it in that cycle or lose it.
interface spi_line_conditioner_if;
    import spi_pkg::*;

    logic                     ss_in;
    logic                     mosi_in;
    logic                     sck_in;
    logic                     err_clr;
    logic                     ss_clean;
    logic                     mosi_clean;
    logic                     sck_clean;
    logic                     sck_rise;
    logic                     sck_fall;
    logic                     mosi_bit;
    logic [SPI_BIT_IDX_W-1:0] bit_idx;
    logic                     byte_strobe;
    logic                     frame_start;
    logic                     frame_end;
    logic                     frame_active;
    logic                     framing_error;
    logic                     timeout;
    spi_state_e               state_dbg;

    modport master (
        output ss_in, mosi_in, sck_in, err_clr,
        input  ss_clean, mosi_clean, sck_clean, sck_rise, sck_fall, mosi_bit,
               bit_idx, byte_strobe, frame_start, frame_end, frame_active,
               framing_error, timeout, state_dbg
    );

    modport slave (
        input  ss_in, mosi_in, sck_in, err_clr,
        output ss_clean, mosi_clean, sck_clean, sck_rise, sck_fall, mosi_bit,
               bit_idx, byte_strobe, frame_start, frame_end, frame_active,
               framing_error, timeout, state_dbg
    );

endinterface

// File: rtl/spi_line_conditioner_line_filter.sv
// One raw line: 2-FF synchroniser, stability filter and edge pulses taken
// from the registered clean value against its previous value.
module line_filter
    import spi_pkg::*;
#(
    parameter int   FILTER_LEN = DEFAULT_FILTER_LEN,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             clean_q;
    logic             clean_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bring the asynchronous line into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
        end
    end

    // Only a disagreement held for FILTER_LEN cycles flips the clean value.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = '0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = ~clean_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state plus a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clean_q <= RESET_VAL;
            prev_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            clean_q <= clean_d;
            prev_q  <= clean_q;
            cnt_q   <= cnt_d;
        end
    end

    assign clean_o = clean_q;
    assign rise_o  = clean_q & ~prev_q;
    assign fall_o  = ~clean_q & prev_q;

endmodule

// File: rtl/spi_line_conditioner.sv
// SPI slave front-end: conditions ss/mosi/sck and turns them into frame,
// bit and byte events, with framing-error and stall detection.
module spi_line_conditioner
    import spi_pkg::*;
#(
    parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_line_conditioner_if.slave  bus
);

    localparam int               TMO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic ss_clean, ss_rise, ss_fall;
    logic mosi_clean, mosi_rise_unused, mosi_fall_unused;
    logic sck_clean, sck_rise_raw, sck_fall_raw;

    spi_state_e               state_q, state_d;
    logic [SPI_BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                     mosi_bit_q, mosi_bit_d;
    logic                     ferr_q, ferr_d;
    logic [TMO_W-1:0]         tmo_cnt_q, tmo_cnt_d;

    logic frame_start, frame_end, frame_active;
    logic sck_rise, sck_fall, byte_strobe, timeout, tmo_hit;

    line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b1)) u_ss_filter (
        .clk(clk), .rst(rst), .line_i(bus.ss_in),
        .clean_o(ss_clean), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_mosi_filter (
        .clk(clk), .rst(rst), .line_i(bus.mosi_in),
        .clean_o(mosi_clean), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    line_filter #(.FILTER_LEN(FILTER_LEN), .RESET_VAL(1'b0)) u_sck_filter (
        .clk(clk), .rst(rst), .line_i(bus.sck_in),
        .clean_o(sck_clean), .rise_o(sck_rise_raw), .fall_o(sck_fall_raw)
    );

    // Stall fires only on a quiet cycle; an sck edge in that cycle restarts the count.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST) && !sck_rise_raw && !sck_fall_raw;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: ss rise always closes the frame, ahead of any stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (ss_fall) state_d = ST_ACTIVE;
            ST_ACTIVE:  if (ss_rise) state_d = ST_IDLE;
                        else if (tmo_hit) state_d = ST_STALLED;
            ST_STALLED: if (ss_rise) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: sck edges count only in ACTIVE and lose to a same-cycle ss rise.
    always_comb begin
        frame_start  = 1'b0;
        frame_end    = 1'b0;
        frame_active = 1'b0;
        sck_rise     = 1'b0;
        sck_fall     = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            ST_IDLE: frame_start = ss_fall;
            ST_ACTIVE: begin
                frame_active = 1'b1;
                frame_end    = ss_rise;
                sck_rise     = sck_rise_raw && !ss_rise;
                sck_fall     = sck_fall_raw && !ss_rise;
                timeout      = tmo_hit && !ss_rise;
            end
            ST_STALLED: begin
                frame_active = 1'b1;
                frame_end    = ss_rise;
            end
            default: ;
        endcase
        byte_strobe = sck_rise && (bit_idx_q == SPI_BIT_IDX_W'(SPI_BITS_PER_BYTE - 1));
    end

    // Datapath next state: bit counter, captured bit, sticky error, stall counter.
    always_comb begin
        bit_idx_d  = bit_idx_q;
        mosi_bit_d = mosi_bit_q;
        ferr_d     = ferr_q;
        tmo_cnt_d  = tmo_cnt_q;
        if (frame_start || frame_end) begin
            bit_idx_d = '0;
        end else if (sck_rise) begin
            bit_idx_d  = bit_idx_q + 1'b1;
            mosi_bit_d = mosi_clean;
        end
        if (frame_end && (bit_idx_q != '0)) begin
            ferr_d = 1'b1;
        end else if (bus.err_clr) begin
            ferr_d = 1'b0;
        end
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_ACTIVE) begin
            if (sck_rise_raw || sck_fall_raw) tmo_cnt_d = '0;
            else if (tmo_cnt_q != '1)         tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_idx_q  <= '0;
            mosi_bit_q <= 1'b0;
            ferr_q     <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            bit_idx_q  <= bit_idx_d;
            mosi_bit_q <= mosi_bit_d;
            ferr_q     <= ferr_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign bus.ss_clean      = ss_clean;
    assign bus.mosi_clean    = mosi_clean;
    assign bus.sck_clean     = sck_clean;
    assign bus.sck_rise      = sck_rise;
    assign bus.sck_fall      = sck_fall;
    assign bus.mosi_bit      = mosi_bit_q;
    assign bus.bit_idx       = bit_idx_q;
    assign bus.byte_strobe   = byte_strobe;
    assign bus.frame_start   = frame_start;
    assign bus.frame_end     = frame_end;
    assign bus.frame_active  = frame_active;
    assign bus.framing_error = ferr_q;
    assign bus.timeout       = timeout;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_spi_line_conditioner.sv
// Bench for spi_line_conditioner: frame table, glitch, stall and reset cases.
module tb_spi_line_conditioner;
    import spi_pkg::*;

    localparam int FLEN = 4;
    localparam int TMO  = 100;
    localparam int HALF = 40;

    typedef struct {
        logic [15:0] data;
        int          nbits;
        int          exp_bytes;
        int          exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_line_conditioner_if bus();

    spi_line_conditioner #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rise = 0, n_fall = 0, n_byte = 0, n_fstart = 0, n_fend = 0, n_tmo = 0;
    logic [0:0] exp_q[$];
    logic       pend = 1'b0;
    logic [0:0] pend_exp = 1'b0;
    vec_t       vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample #1 after the edge, run the scoreboard and event counters.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            if (pend) begin
                check("mosi_bit", int'(bus.mosi_bit), int'(pend_exp));
                pend = 1'b0;
            end
            if (bus.sck_rise) begin
                n_rise++;
                check("rise_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    pend_exp = exp_q.pop_front();
                    pend     = 1'b1;
                end
            end
            if (bus.byte_strobe) begin
                n_byte++;
                check("byte_at_bit7", int'(bus.bit_idx), 7);
            end
            if (bus.sck_fall)    n_fall++;
            if (bus.frame_start) n_fstart++;
            if (bus.frame_end)   n_fend++;
            if (bus.timeout)     n_tmo++;
        end else begin
            pend = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic frame_open();
        bus.ss_in = 1'b0;
        wait_cycles(20);
    endtask

    task automatic send_bit(input logic b);
        bus.mosi_in = b;
        exp_q.push_back(b);
        wait_cycles(HALF);
        bus.sck_in = 1'b1;
        wait_cycles(HALF);
        bus.sck_in = 1'b0;
    endtask

    task automatic frame_close();
        wait_cycles(20);
        bus.ss_in = 1'b1;
        wait_cycles(20);
    endtask

    task automatic send_frame(input logic [15:0] data, input int nbits);
        frame_open();
        for (int i = 0; i < nbits; i++) send_bit(data[nbits-1-i]);
        frame_close();
    endtask

    initial begin
        int b_rise, b_fall, b_byte, b_fs, b_fe, b_tmo;

        vecs[0] = '{16'h001C, 5,  0, 1};
        vecs[1] = '{16'hFFFF, 16, 2, 0};
        vecs[2] = '{16'h0000, 8,  1, 0};
        vecs[3] = '{16'h0005, 3,  0, 1};
        vecs[4] = '{16'h0234, 12, 1, 1};
        vecs[5] = '{16'hC3A5, 16, 2, 0};

        bus.ss_in = 1'b1; bus.mosi_in = 1'b0; bus.sck_in = 1'b0; bus.err_clr = 1'b0;

        // Reset values while held in reset, then 1000 idle cycles.
        repeat (5) @(posedge clk);
        #1;
        check("rst_ss_clean", int'(bus.ss_clean), 1);
        check("rst_frame_active", int'(bus.frame_active), 0);
        rst = 1'b1;
        wait_cycles(1000);
        check("idle_ss_clean", int'(bus.ss_clean), 1);
        check("idle_mosi_clean", int'(bus.mosi_clean), 0);
        check("idle_sck_clean", int'(bus.sck_clean), 0);
        check("idle_bit_idx", int'(bus.bit_idx), 0);
        check("idle_mosi_bit", int'(bus.mosi_bit), 0);
        check("idle_ferr", int'(bus.framing_error), 0);
        check("idle_state", int'(bus.state_dbg), int'(ST_IDLE));
        check("idle_events", n_rise + n_fall + n_byte + n_fstart + n_fend + n_tmo, 0);

        // First frame: ss latency, then 0xA5 MSB first.
        bus.ss_in = 1'b0;
        wait_cycles(5);
        check("ss_latency_5", int'(bus.ss_clean), 1);
        wait_cycles(1);
        check("ss_latency_6", int'(bus.ss_clean), 0);
        check("frame_start_now", int'(bus.frame_start), 1);
        wait_cycles(14);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] a5;
            a5 = 8'hA5;
            send_bit(a5[i]);
        end
        frame_close();
        check("a5_fstart", n_fstart, 1);
        check("a5_fend", n_fend, 1);
        check("a5_rise", n_rise, 8);
        check("a5_fall", n_fall, 8);
        check("a5_byte", n_byte, 1);
        check("a5_bit_idx", int'(bus.bit_idx), 0);
        check("a5_ferr", int'(bus.framing_error), 0);
        check("a5_queue_empty", exp_q.size(), 0);

        // Frame table: partial and multi-byte frames, sticky error and clear.
        for (int v = 0; v < 6; v++) begin
            b_rise = n_rise; b_byte = n_byte; b_fs = n_fstart; b_fe = n_fend;
            send_frame(vecs[v].data, vecs[v].nbits);
            check("tbl_fstart", n_fstart - b_fs, 1);
            check("tbl_fend", n_fend - b_fe, 1);
            check("tbl_rise", n_rise - b_rise, vecs[v].nbits);
            check("tbl_byte", n_byte - b_byte, vecs[v].exp_bytes);
            check("tbl_bit_idx", int'(bus.bit_idx), 0);
            check("tbl_queue_empty", exp_q.size(), 0);
            wait_cycles(50);
            check("tbl_ferr", int'(bus.framing_error), vecs[v].exp_ferr);
            bus.err_clr = 1'b1;
            tick();
            bus.err_clr = 1'b0;
            tick();
            check("tbl_ferr_cleared", int'(bus.framing_error), 0);
        end

        // Glitches in IDLE; then a real sck pulse that must not count.
        b_rise = n_rise; b_fall = n_fall; b_fs = n_fstart;
        bus.sck_in = 1'b1; wait_cycles(2); bus.sck_in = 1'b0; wait_cycles(10);
        bus.ss_in = 1'b0; wait_cycles(2); bus.ss_in = 1'b1; wait_cycles(20);
        check("glitch_idle_sck", int'(bus.sck_clean), 0);
        check("glitch_idle_ss", int'(bus.ss_clean), 1);
        check("glitch_idle_fstart", n_fstart - b_fs, 0);
        bus.sck_in = 1'b1; wait_cycles(10);
        check("idle_sck_tracks", int'(bus.sck_clean), 1);
        bus.sck_in = 1'b0; wait_cycles(10);
        check("idle_sck_no_strobe", (n_rise - b_rise) + (n_fall - b_fall), 0);
        check("idle_sck_bit_idx", int'(bus.bit_idx), 0);

        // Glitches mid-byte must leave bit_idx and the frame alone.
        b_rise = n_rise; b_byte = n_byte; b_fe = n_fend;
        frame_open();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        wait_cycles(10);
        bus.sck_in = 1'b1; wait_cycles(2); bus.sck_in = 1'b0; wait_cycles(10);
        bus.ss_in = 1'b1; wait_cycles(2); bus.ss_in = 1'b0; wait_cycles(20);
        check("glitch_mid_bit_idx", int'(bus.bit_idx), 3);
        check("glitch_mid_rise", n_rise - b_rise, 3);
        check("glitch_mid_fend", n_fend - b_fe, 0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        frame_close();
        check("glitch_mid_byte", n_byte - b_byte, 1);
        check("glitch_mid_ferr", int'(bus.framing_error), 0);

        // Stall: no sck for longer than the timeout, then ignored sck pulses.
        b_rise = n_rise; b_tmo = n_tmo; b_fe = n_fend;
        bus.ss_in = 1'b0;
        wait_cycles(250);
        check("stall_timeout_once", n_tmo - b_tmo, 1);
        check("stall_state", int'(bus.state_dbg), int'(ST_STALLED));
        check("stall_frame_active", int'(bus.frame_active), 1);
        repeat (3) begin
            bus.sck_in = 1'b1; wait_cycles(HALF);
            bus.sck_in = 1'b0; wait_cycles(HALF);
        end
        check("stall_no_rise", n_rise - b_rise, 0);
        check("stall_timeout_still_once", n_tmo - b_tmo, 1);
        bus.ss_in = 1'b1;
        wait_cycles(20);
        check("stall_fend", n_fend - b_fe, 1);
        check("stall_back_idle", int'(bus.state_dbg), int'(ST_IDLE));
        check("stall_frame_inactive", int'(bus.frame_active), 0);
        check("stall_ferr", int'(bus.framing_error), 0);

        // Reset mid-byte at bit_idx 3, then a clean frame from bit 0.
        b_fe = n_fend;
        frame_open();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_cycles(5);
        check("pre_rst_bit_idx", int'(bus.bit_idx), 3);
        rst = 1'b0;
        #1;
        check("midrst_bit_idx", int'(bus.bit_idx), 0);
        check("midrst_frame_active", int'(bus.frame_active), 0);
        check("midrst_ss_clean", int'(bus.ss_clean), 1);
        check("midrst_frame_end", int'(bus.frame_end), 0);
        check("midrst_state", int'(bus.state_dbg), int'(ST_IDLE));
        bus.ss_in = 1'b1; bus.mosi_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        b_fs = n_fstart; b_byte = n_byte; b_rise = n_rise;
        wait_cycles(20);
        check("postrst_no_fstart", n_fstart - b_fs, 0);
        check("postrst_no_fend", n_fend - b_fe, 0);
        send_frame(16'h0096, 8);
        check("postrst_rise", n_rise - b_rise, 8);
        check("postrst_byte", n_byte - b_byte, 1);
        check("postrst_ferr", int'(bus.framing_error), 0);
        check("postrst_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
